snoop_resp_collector: RTL and testbench

SNOOP_RESP_COLLECTOR -- requirements
Module: snoop_resp_collector

---
 rtl/snoop_resp_collector.sv | 221 ++++++++++++++++++++++
 tb/tb_snoop_resp_collector.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_resp_collector.sv
// ---------------------------------------------------------------------------
// snoop_resp_collector
//
// Purpose:
//   Runs one granted bus request at a time. It broadcasts a snoop to every
//   peer L1 and collects their "shared" replies. If a peer supplies the line,
//   that data is returned. Otherwise a read (BUS_RD/BUS_RDX) is sent to L2,
//   or an address-only request (BUS_UPGR/BUS_WB) completes with zero data.
//   Completion is a single-cycle resp_valid pulse. The response fields keep
//   their values until the next completion.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only when idle)
//   req_core/addr/type      requesting core id, line address, request type
//   snoop_valid[NCORES]     one-cycle snoop strobe to every core but the requester
//   snoop_addr/snoop_req    latched address/type broadcast to the peers
//   snoop_shared[NCORES]    per-core "I am supplying data" flags
//   snoop_data              per-core lines, core i at [i*LINE_W +: LINE_W]
//   mem_rd_valid/ready/addr L2 read request handshake
//   mem_resp_valid/data     L2 read data return
//   resp_valid              one-cycle completion pulse
//   resp_core/data/shared   requester id, returned line, peer-supplied flag
//
// Request type encoding (req_type/snoop_req):
//   2'd0 BUS_RD, 2'd1 BUS_RDX, 2'd2 BUS_UPGR, 2'd3 BUS_WB
// ---------------------------------------------------------------------------

`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

module snoop_resp_collector #(
  parameter int NCORES  = 4,
  parameter int LADDR_W = `ADDR_BITS - `OFFSET_BITS,
  parameter int LINE_W  = `CACHELINE_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  // request side
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [$clog2(NCORES)-1:0]  req_core,
  input  logic [LADDR_W-1:0]         req_addr,
  input  logic [1:0]                 req_type,
  // snoop side
  output logic [NCORES-1:0]          snoop_valid,
  output logic [LADDR_W-1:0]         snoop_addr,
  output logic [1:0]                 snoop_req,
  input  logic [NCORES-1:0]          snoop_shared,
  input  logic [NCORES*LINE_W-1:0]   snoop_data,
  // memory side
  output logic                       mem_rd_valid,
  input  logic                       mem_rd_ready,
  output logic [LADDR_W-1:0]         mem_rd_addr,
  input  logic                       mem_resp_valid,
  input  logic [LINE_W-1:0]          mem_resp_data,
  // response side
  output logic                       resp_valid,
  output logic [$clog2(NCORES)-1:0]  resp_core,
  output logic [LINE_W-1:0]          resp_data,
  output logic                       resp_shared
);

  localparam int CORE_W = $clog2(NCORES);

  localparam logic [1:0] BUS_RD   = 2'd0;
  localparam logic [1:0] BUS_RDX  = 2'd1;
  localparam logic [1:0] BUS_UPGR = 2'd2;
  localparam logic [1:0] BUS_WB   = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SNOOP    = 3'd1,
    COLLECT  = 3'd2,
    MEM_REQ  = 3'd3,
    MEM_WAIT = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CORE_W-1:0]    core_q;
  logic [LADDR_W-1:0]   addr_q;
  logic [1:0]           type_q;
  logic [LINE_W-1:0]    resp_data_q, resp_data_d;
  logic                 resp_shared_q, resp_shared_d;
  logic [CORE_W-1:0]    resp_core_q, resp_core_d;

  logic [NCORES-1:0]    hit;
  logic [LINE_W-1:0]    lane [NCORES];
  logic [LINE_W-1:0]    peer_data;
  logic                 accept;

  // Per-core slicing: data lanes, hit vector with the requester masked out,
  // and the snoop strobe that skips the requester.
  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_core
      assign lane[gi]        = snoop_data[gi*LINE_W +: LINE_W];
      assign hit[gi]         = snoop_shared[gi] && (core_q != CORE_W'(gi));
      assign snoop_valid[gi] = (state_q == SNOOP) && !reset && (core_q != CORE_W'(gi));
    end
  endgenerate

  // Lowest-indexed supplier wins: scan downward so the lowest hit is written last.
  always_comb begin
    peer_data = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        peer_data = lane[i];
      end
    end
  end

  // Strobes are forced low while reset is held, even before the reset edge.
  assign req_ready    = (state_q == IDLE) && !reset;
  assign mem_rd_valid = (state_q == MEM_REQ) && !reset;
  assign resp_valid   = (state_q == RESP) && !reset;
  assign accept       = req_valid && req_ready;

  assign snoop_addr   = addr_q;
  assign snoop_req    = type_q;
  assign mem_rd_addr  = addr_q;
  assign resp_data    = resp_data_q;
  assign resp_shared  = resp_shared_q;
  assign resp_core    = resp_core_q;

  // Next-state and response capture
  always_comb begin
    state_d       = state_q;
    resp_data_d   = resp_data_q;
    resp_shared_d = resp_shared_q;
    resp_core_d   = resp_core_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SNOOP;
        end
      end

      SNOOP: begin
        state_d = COLLECT;
      end

      COLLECT: begin
        if (|hit) begin
          resp_data_d   = peer_data;
          resp_shared_d = 1'b1;
          resp_core_d   = core_q;
          state_d       = RESP;
        end else begin
          case (type_q)
            BUS_RD, BUS_RDX: begin
              state_d = MEM_REQ;
            end
            BUS_UPGR, BUS_WB: begin
              // Address-only requests need no line when no peer supplies one.
              resp_data_d   = '0;
              resp_shared_d = 1'b0;
              resp_core_d   = core_q;
              state_d       = RESP;
            end
          endcase
        end
      end

      MEM_REQ: begin
        if (mem_rd_ready) begin
          state_d = MEM_WAIT;
        end
      end

      MEM_WAIT: begin
        if (mem_resp_valid) begin
          resp_data_d   = mem_resp_data;
          resp_shared_d = 1'b0;
          resp_core_d   = core_q;
          state_d       = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      core_q        <= '0;
      addr_q        <= '0;
      type_q        <= '0;
      resp_data_q   <= '0;
      resp_shared_q <= 1'b0;
      resp_core_q   <= '0;
    end else begin
      state_q       <= state_d;
      resp_data_q   <= resp_data_d;
      resp_shared_q <= resp_shared_d;
      resp_core_q   <= resp_core_d;
      if (accept) begin
        core_q <= req_core;
        addr_q <= req_addr;
        type_q <= req_type;
      end
    end
  end

endmodule

// File: tb/tb_snoop_resp_collector.sv
// ---------------------------------------------------------------------------
// tb_snoop_resp_collector
//
// Directed bench for snoop_resp_collector with NCORES=4. Inputs are driven
// and outputs are sampled on the falling clock edge. Each directed
// transaction is laid out cycle by cycle from its accept cycle T.
// ---------------------------------------------------------------------------
module tb_snoop_resp_collector;

  localparam int NC = 4;
  localparam int AW = 26;
  localparam int LW = 64;

  localparam logic [1:0] RD   = 2'd0;
  localparam logic [1:0] RDX  = 2'd1;
  localparam logic [1:0] UPGR = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam logic [LW-1:0] D_AA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [LW-1:0] D_BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [LW-1:0] D_11 = 64'h1111_1111_1111_1111;
  localparam logic [LW-1:0] D_22 = 64'h2222_2222_2222_2222;
  localparam logic [LW-1:0] D_55 = 64'h5555_5555_5555_5555;
  localparam logic [LW-1:0] D_77 = 64'h7777_7777_7777_7777;
  localparam logic [LW-1:0] D_33 = 64'h3333_3333_3333_3333;
  localparam logic [LW-1:0] D_99 = 64'h9999_9999_9999_9999;
  localparam logic [LW-1:0] D_EE = 64'hEEEE_EEEE_EEEE_EEEE;
  localparam logic [LW-1:0] D_66 = 64'h6666_6666_6666_6666;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_core;
  logic [AW-1:0]     req_addr;
  logic [1:0]        req_type;
  logic [NC-1:0]     snoop_valid;
  logic [AW-1:0]     snoop_addr;
  logic [1:0]        snoop_req;
  logic [NC-1:0]     snoop_shared;
  logic [NC*LW-1:0]  snoop_data;
  logic              mem_rd_valid;
  logic              mem_rd_ready;
  logic [AW-1:0]     mem_rd_addr;
  logic              mem_resp_valid;
  logic [LW-1:0]     mem_resp_data;
  logic              resp_valid;
  logic [1:0]        resp_core;
  logic [LW-1:0]     resp_data;
  logic              resp_shared;

  always #5 clk = ~clk;

  snoop_resp_collector #(
    .NCORES (NC),
    .LADDR_W(AW),
    .LINE_W (LW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_core      (req_core),
    .req_addr      (req_addr),
    .req_type      (req_type),
    .snoop_valid   (snoop_valid),
    .snoop_addr    (snoop_addr),
    .snoop_req     (snoop_req),
    .snoop_shared  (snoop_shared),
    .snoop_data    (snoop_data),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_ready  (mem_rd_ready),
    .mem_rd_addr   (mem_rd_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .resp_valid    (resp_valid),
    .resp_core     (resp_core),
    .resp_data     (resp_data),
    .resp_shared   (resp_shared)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mem_cyc = 0;
  int resp_cyc = 0;
  int m0;
  int r0;

  // Count strobe cycles; sampled at the rising edge before state updates.
  always @(posedge clk) begin
    if (mem_rd_valid) mem_cyc++;
    if (resp_valid) resp_cyc++;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic v, input logic [1:0] core, input logic [AW-1:0] addr,
                           input logic [1:0] typ);
    req_valid = v;
    req_core  = core;
    req_addr  = addr;
    req_type  = typ;
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_core       = '0;
    req_addr       = '0;
    req_type       = '0;
    snoop_shared   = '0;
    snoop_data     = '0;
    mem_rd_ready   = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    // ---------------- reset state ----------------
    tick();
    check_val("rst_req_ready", 64'(req_ready), 64'd0);
    check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_val("rst_snoop_valid", 64'(snoop_valid), 64'd0);
    check_val("rst_mem_rd_valid", 64'(mem_rd_valid), 64'd0);
    tick();
    check_val("rst_resp_data", resp_data, 64'd0);
    check_val("rst_resp_core", 64'(resp_core), 64'd0);
    check_val("rst_resp_shared", 64'(resp_shared), 64'd0);
    check_val("rst_snoop_addr", 64'(snoop_addr), 64'd0);
    check_val("rst_snoop_req", 64'(snoop_req), 64'd0);
    reset = 1'b0;
    tick();
    check_val("rst_release_ready", 64'(req_ready), 64'd1);

    // ---------------- peer supply: RD core0 @0x40, cores 2/3 share ----------------
    m0 = mem_cyc;
    check_val("peer_ready_T", 64'(req_ready), 64'd1);
    drive_req(1'b1, 2'd0, 26'h40, RD);
    tick();  // T+1 SNOOP
    check_val("peer_snoop_valid", 64'(snoop_valid), 64'b1110);
    check_val("peer_snoop_addr", 64'(snoop_addr), 64'h40);
    check_val("peer_snoop_req", 64'(snoop_req), 64'(RD));
    check_val("peer_ready_busy", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    tick();  // T+2 COLLECT
    check_val("peer_snoop_once", 64'(snoop_valid), 64'd0);
    snoop_shared = 4'b1100;
    snoop_data   = {D_BB, D_AA, D_11, D_22};
    tick();  // T+3 RESP
    check_val("peer_resp_valid", 64'(resp_valid), 64'd1);
    check_val("peer_resp_core", 64'(resp_core), 64'd0);
    check_val("peer_resp_data", resp_data, D_AA);
    check_val("peer_resp_shared", 64'(resp_shared), 64'd1);
    snoop_shared = '0;
    snoop_data   = '0;
    tick();  // T+4 IDLE
    check_val("peer_resp_pulse", 64'(resp_valid), 64'd0);
    check_val("peer_data_hold", resp_data, D_AA);
    check_val("peer_no_mem", 64'(mem_cyc - m0), 64'd0);

    // ---------------- memory fill: RDX core1 @0x80 ----------------
    m0 = mem_cyc;
    drive_req(1'b1, 2'd1, 26'h80, RDX);
    tick();  // T+1
    check_val("fill_snoop_valid", 64'(snoop_valid), 64'b1101);
    req_valid = 1'b0;
    tick();  // T+2 COLLECT, no sharers
    check_val("fill_collect_no_mem", 64'(mem_rd_valid), 64'd0);
    tick();  // T+3 MEM_REQ
    check_val("fill_mem_valid_0", 64'(mem_rd_valid), 64'd1);
    check_val("fill_mem_addr", 64'(mem_rd_addr), 64'h80);
    tick();  // T+4
    check_val("fill_mem_valid_1", 64'(mem_rd_valid), 64'd1);
    tick();  // T+5 handshake
    check_val("fill_mem_valid_2", 64'(mem_rd_valid), 64'd1);
    mem_rd_ready = 1'b1;
    tick();  // T+6 MEM_WAIT
    mem_rd_ready = 1'b0;
    check_val("fill_mem_dropped", 64'(mem_rd_valid), 64'd0);
    tick();  // T+7
    tick();  // T+8 data arrives
    check_val("fill_wait_no_resp", 64'(resp_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = D_55;
    tick();  // T+9 RESP
    mem_resp_valid = 1'b0;
    check_val("fill_resp_valid", 64'(resp_valid), 64'd1);
    check_val("fill_resp_data", resp_data, D_55);
    check_val("fill_resp_shared", 64'(resp_shared), 64'd0);
    check_val("fill_resp_core", 64'(resp_core), 64'd1);
    check_val("fill_mem_cycles", 64'(mem_cyc - m0), 64'd3);
    tick();  // T+10 IDLE: stray memory data must be ignored
    check_val("fill_resp_pulse", 64'(resp_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = D_99;
    tick();  // T+11
    mem_resp_valid = 1'b0;
    check_val("stray_idle_no_resp", 64'(resp_valid), 64'd0);
    check_val("stray_idle_data_hold", resp_data, D_55);

    // ---------------- requester mask: RD core2, only shared[2] ----------------
    drive_req(1'b1, 2'd2, 26'hC0, RD);
    tick();  // T+1
    req_valid = 1'b0;
    tick();  // T+2 COLLECT
    snoop_shared = 4'b0100;
    snoop_data   = {64'd0, D_77, 64'd0, 64'd0};
    tick();  // T+3 MEM_REQ
    snoop_shared = '0;
    snoop_data   = '0;
    check_val("mask_goes_mem", 64'(mem_rd_valid), 64'd1);
    check_val("mask_no_resp", 64'(resp_valid), 64'd0);
    mem_rd_ready = 1'b1;
    tick();  // T+4 MEM_WAIT, data on the earliest legal cycle
    mem_rd_ready   = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = D_33;
    tick();  // T+5 RESP
    mem_resp_valid = 1'b0;
    check_val("mask_resp_valid", 64'(resp_valid), 64'd1);
    check_val("mask_resp_data", resp_data, D_33);
    check_val("mask_resp_shared", 64'(resp_shared), 64'd0);
    check_val("mask_resp_core", 64'(resp_core), 64'd2);
    tick();  // IDLE

    // ---------------- upgrade: UPGR core3, only requester bit set ----------------
    m0 = mem_cyc;
    drive_req(1'b1, 2'd3, 26'h1C0, UPGR);
    tick();  // T+1
    check_val("upgr_snoop_valid", 64'(snoop_valid), 64'b0111);
    check_val("upgr_snoop_req", 64'(snoop_req), 64'(UPGR));
    req_valid = 1'b0;
    tick();  // T+2
    snoop_shared = 4'b1000;
    snoop_data   = {D_EE, 64'd0, 64'd0, 64'd0};
    tick();  // T+3 RESP
    snoop_shared = '0;
    snoop_data   = '0;
    check_val("upgr_resp_valid", 64'(resp_valid), 64'd1);
    check_val("upgr_resp_data", resp_data, 64'd0);
    check_val("upgr_resp_shared", 64'(resp_shared), 64'd0);
    check_val("upgr_resp_core", 64'(resp_core), 64'd3);
    tick();  // T+4
    check_val("upgr_no_mem", 64'(mem_cyc - m0), 64'd0);

    // ---------------- reset in MEM_WAIT, stray data afterwards ----------------
    r0 = resp_cyc;
    drive_req(1'b1, 2'd0, 26'h10, RD);
    tick();  // T+1
    req_valid = 1'b0;
    tick();  // T+2
    tick();  // T+3 MEM_REQ
    mem_rd_ready = 1'b1;
    tick();  // T+4 MEM_WAIT
    mem_rd_ready = 1'b0;
    reset = 1'b1;
    tick();  // T+5 reset sampled
    check_val("abort_no_resp", 64'(resp_valid), 64'd0);
    check_val("abort_ready_in_rst", 64'(req_ready), 64'd0);
    reset          = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = D_66;
    #1;
    check_val("abort_first_ready", 64'(req_ready), 64'd1);
    tick();  // T+6
    mem_resp_valid = 1'b0;
    check_val("abort_stray_no_resp", 64'(resp_valid), 64'd0);
    check_val("abort_still_idle", 64'(req_ready), 64'd1);
    check_val("abort_resp_data", resp_data, 64'd0);
    check_val("abort_resp_count", 64'(resp_cyc - r0), 64'd0);

    // ---------------- back-to-back: req_valid held across two requests ----------------
    drive_req(1'b1, 2'd1, 26'h100, UPGR);
    tick();  // T+1 first accepted at T
    check_val("b2b_busy_1", 64'(req_ready), 64'd0);
    drive_req(1'b1, 2'd2, 26'h140, WB);
    tick();  // T+2
    tick();  // T+3 first RESP
    check_val("b2b_resp1_valid", 64'(resp_valid), 64'd1);
    check_val("b2b_resp1_core", 64'(resp_core), 64'd1);
    check_val("b2b_busy_resp", 64'(req_ready), 64'd0);
    tick();  // T+4 second accepted
    check_val("b2b_ready_after_resp", 64'(req_ready), 64'd1);
    check_val("b2b_resp1_pulse", 64'(resp_valid), 64'd0);
    tick();  // T+5 SNOOP of second
    req_valid = 1'b0;
    check_val("b2b_snoop_valid", 64'(snoop_valid), 64'b1011);
    check_val("b2b_snoop_addr", 64'(snoop_addr), 64'h140);
    check_val("b2b_snoop_req", 64'(snoop_req), 64'(WB));
    tick();  // T+6 COLLECT
    tick();  // T+7 RESP of second
    check_val("b2b_resp2_valid", 64'(resp_valid), 64'd1);
    check_val("b2b_resp2_core", 64'(resp_core), 64'd2);
    check_val("b2b_resp2_data", resp_data, 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
